q_pipe_ctrl: RTL and testbench



---
 rtl/q_pipe_ctrl.sv | 155 +++++++++++++++
 tb/tb_q_pipe_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/q_pipe_ctrl.sv
// q_pipe_ctrl: sequencer for a linear chain of Q-flop stages.
// Tracks stage occupancy and issues one-cycle load pulses. After each step it
// holds until every pulsed stage acknowledges through a 2-flop synchronizer.
// A stage that fails to acknowledge in time leaves the block in a sticky
// error state until reset.
module q_pipe_ctrl #(
   parameter  int STAGES      = 4,
   parameter  int ACK_TIMEOUT = 15,
   localparam int SW          = (STAGES > 1) ? $clog2(STAGES) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [STAGES-1:0] stage_ld,
   input  logic [STAGES-1:0] stage_ack,
   output logic [STAGES-1:0] occ,
   output logic              err,
   output logic [SW-1:0]     err_stage
);

   typedef enum logic [2:0] {
      S_IDLE, S_PULSE, S_SETTLE1, S_SETTLE2, S_WAIT, S_ERR
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [STAGES-1:0]   r_ack_p0;
   logic [STAGES-1:0]   r_ack_p1;
   logic [STAGES-1:0]   r_occ;
   logic [STAGES-1:0]   r_stage_ld;
   logic [STAGES-1:0]   r_pmask;
   logic [7:0]          r_tcnt;
   logic                r_err;
   logic [SW-1:0]       r_err_stage;

   logic [STAGES-1:0]   w_sack;
   logic                w_drain;
   logic [STAGES-1:0]   w_mv;
   logic [STAGES-1:0]   w_load;
   logic                w_in_ready;
   logic                w_ack_ok;
   logic                w_tmo;
   logic [SW-1:0]       w_err_idx;

   assign w_sack   = r_ack_p1;
   assign w_drain  = r_occ[STAGES-1] && out_ready;
   assign w_ack_ok = ((w_sack & r_pmask) == r_pmask);
   assign w_tmo    = (r_tcnt == 8'(ACK_TIMEOUT - 1));

   // Resynchronize the asynchronous per-stage acks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ack_p0 <= '0;
         r_ack_p1 <= '0;
      end else begin
         r_ack_p0 <= stage_ack;
         r_ack_p1 <= r_ack_p0;
      end
   end

   // Move chain: a stage advances if its successor is empty or also advancing.
   always_comb begin
      logic v_go;
      w_mv           = '0;
      v_go           = w_drain;
      w_mv[STAGES-1] = w_drain;
      for (int i = STAGES - 2; i >= 0; i--) begin
         v_go    = r_occ[i] && (!r_occ[i+1] || v_go);
         w_mv[i] = v_go;
      end
   end

   assign w_in_ready = (r_state == S_IDLE) && !rst && (!r_occ[0] || w_mv[0]);
   assign w_load     = {w_mv[STAGES-2:0], in_valid && w_in_ready};

   // Lowest pulsed stage whose synchronized ack is still low.
   always_comb begin
      w_err_idx = '0;
      for (int i = STAGES - 1; i >= 0; i--) begin
         if (r_pmask[i] && !w_sack[i]) w_err_idx = SW'(i);
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // FSM next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (|w_load) w_next = S_PULSE;
         S_PULSE:   w_next = S_SETTLE1;
         S_SETTLE1: w_next = S_SETTLE2;
         S_SETTLE2: w_next = S_WAIT;
         S_WAIT: begin
            if (w_ack_ok)   w_next = S_IDLE;
            else if (w_tmo) w_next = S_ERR;
         end
         S_ERR:     w_next = S_ERR;
         default:   w_next = S_IDLE;
      endcase
   end

   // FSM outputs: handshakes are only offered while idle.
   always_comb begin
      in_ready  = w_in_ready;
      out_valid = (r_state == S_IDLE) && r_occ[STAGES-1];
   end

   // Occupancy, load pulses, ack timer and sticky error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_occ       <= '0;
         r_stage_ld  <= '0;
         r_pmask     <= '0;
         r_tcnt      <= '0;
         r_err       <= 1'b0;
         r_err_stage <= '0;
      end else begin
         r_stage_ld <= '0;
         case (r_state)
            S_IDLE: begin
               r_occ <= (r_occ & ~w_mv) | w_load;
               if (|w_load) begin
                  r_stage_ld <= w_load;
                  r_pmask    <= w_load;
               end
            end
            S_SETTLE2: r_tcnt <= '0;
            S_WAIT: begin
               if (!w_ack_ok) begin
                  r_tcnt <= r_tcnt + 8'd1;
                  if (w_tmo) begin
                     r_err       <= 1'b1;
                     r_err_stage <= w_err_idx;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign stage_ld  = r_stage_ld;
   assign occ       = r_occ;
   assign err       = r_err;
   assign err_stage = r_err_stage;

endmodule

// File: tb/tb_q_pipe_ctrl.sv
// Testbench for q_pipe_ctrl: directed sequence with a queue of expected
// load-pulse patterns and a behavioural Q-flop ack model.
module tb_q_pipe_ctrl;

   localparam int STAGES      = 4;
   localparam int ACK_TIMEOUT = 15;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic                out_valid;
   logic                out_ready;
   logic [STAGES-1:0]   stage_ld;
   logic [STAGES-1:0]   stage_ack;
   logic [STAGES-1:0]   occ;
   logic                err;
   logic [1:0]          err_stage;

   int                  n_vec = 0;
   int                  n_bad = 0;
   logic [STAGES-1:0]   exp_q[$];

   int                  ack_dly = 3;
   logic [STAGES-1:0]   stuck   = '0;
   int                  ack_cnt[STAGES];

   q_pipe_ctrl #(.STAGES(STAGES), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .stage_ld  (stage_ld),
      .stage_ack (stage_ack),
      .occ       (occ),
      .err       (err),
      .err_stage (err_stage)
   );

   initial forever #5 clk = ~clk;

   // Q-flop model: ack drops during the load pulse, returns ack_dly falling
   // edges later unless the stage is forced stuck.
   initial begin
      stage_ack = '1;
      for (int i = 0; i < STAGES; i++) ack_cnt[i] = 0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < STAGES; i++) begin
            if (stage_ld[i]) begin
               ack_cnt[i]   = ack_dly;
               stage_ack[i] = 1'b0;
            end else begin
               if (ack_cnt[i] > 0) ack_cnt[i]--;
               stage_ack[i] = (ack_cnt[i] == 0) && !stuck[i];
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and pop/compare any load pulse the DUT issued.
   task automatic step();
      logic [STAGES-1:0] e;
      @(posedge clk);
      #1;
      if (stage_ld !== '0) begin
         if (exp_q.size() == 0) begin
            chk("ld_unexpected", 32'(stage_ld), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("stage_ld", 32'(stage_ld), 32'(e));
         end
      end
   endtask

   task automatic wait_idle(input int max, output int n);
      n = 0;
      while (!(in_ready || out_valid) && n < max) begin
         step();
         n++;
      end
   endtask

   task automatic wait_err(input int max, output int n);
      n = 0;
      while (!err && n < max) begin
         step();
         n++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      step();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      int n;
      rst       = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_stage_ld",  32'(stage_ld),  32'd0);
      chk("rst_occ",       32'(occ),       32'd0);
      chk("rst_err",       32'(err),       32'd0);
      chk("rst_err_stage", 32'(err_stage), 32'd0);
      in_valid = 1'b0;
      rst      = 1'b0;
      #1;
      chk("rel_in_ready", 32'(in_ready), 32'd1);

      // single token walks through all four stages
      exp_q.push_back(4'b0001);
      exp_q.push_back(4'b0010);
      exp_q.push_back(4'b0100);
      exp_q.push_back(4'b1000);
      in_valid = 1'b1;
      #1;
      chk("tok_in_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         wait_idle(40, n);
         chk("tok_period", 32'(n), 32'd6);
         chk("tok_occ", 32'(occ), 32'd1 << k);
         if (k < 3) step();
      end
      chk("tok_out_valid", 32'(out_valid), 32'd1);
      step();
      step();
      chk("tok_hold_occ", 32'(occ), 32'h8);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      #1;
      chk("drain_occ",       32'(occ),       32'd0);
      chk("drain_out_valid", 32'(out_valid), 32'd0);
      chk("drain_no_ld",     32'(stage_ld),  32'd0);
      chk("tok_q_empty",     32'(exp_q.size()), 32'd0);

      // fill with out_ready low
      exp_q.push_back(4'b0001);
      exp_q.push_back(4'b0011);
      exp_q.push_back(4'b0111);
      exp_q.push_back(4'b1111);
      in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         wait_idle(40, n);
         chk("fill_period", 32'(n), 32'd6);
      end
      chk("full_occ",       32'(occ),       32'hF);
      chk("full_in_ready",  32'(in_ready),  32'd0);
      chk("full_out_valid", 32'(out_valid), 32'd1);
      step();
      step();
      chk("full_hold_occ",  32'(occ),       32'hF);
      exp_q.push_back(4'b1111);
      out_ready = 1'b1;
      #1;
      chk("shift_in_ready", 32'(in_ready), 32'd1);
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("shift_occ", 32'(occ), 32'hF);
      wait_idle(40, n);
      chk("shift_period", 32'(n), 32'd6);
      chk("shift_occ_idle", 32'(occ), 32'hF);
      chk("fill_q_empty", 32'(exp_q.size()), 32'd0);
      do_reset();
      chk("rst2_occ", 32'(occ), 32'd0);

      // stage 2 never acknowledges
      stuck = 4'b0100;
      exp_q.push_back(4'b0001);
      exp_q.push_back(4'b0010);
      exp_q.push_back(4'b0100);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      wait_idle(40, n);
      step();
      wait_idle(40, n);
      step();
      wait_err(40, n);
      chk("tmo_cycles",     32'(n),         32'd18);
      chk("tmo_err",        32'(err),       32'd1);
      chk("tmo_err_stage",  32'(err_stage), 32'd2);
      chk("tmo_in_ready",   32'(in_ready),  32'd0);
      chk("tmo_out_valid",  32'(out_valid), 32'd0);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      repeat (3) step();
      chk("err_in_ready",  32'(in_ready),  32'd0);
      chk("err_out_valid", 32'(out_valid), 32'd0);
      chk("err_occ",       32'(occ),       32'h4);
      chk("err_sticky",    32'(err),       32'd1);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("err_rst_err",   32'(err),       32'd0);
      chk("err_rst_stage", 32'(err_stage), 32'd0);
      chk("err_rst_occ",   32'(occ),       32'd0);
      stuck = '0;
      step();
      rst = 1'b0;
      #1;

      // ack arriving on the last allowed WAIT cycle, then one cycle too late
      ack_dly = 15;
      exp_q.push_back(4'b0001);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      wait_idle(40, n);
      chk("bnd_pass_cycles", 32'(n),   32'd18);
      chk("bnd_pass_err",    32'(err), 32'd0);
      chk("bnd_pass_occ",    32'(occ), 32'h1);
      ack_dly = 16;
      exp_q.push_back(4'b0010);
      step();
      wait_err(40, n);
      chk("bnd_fail_cycles", 32'(n),         32'd18);
      chk("bnd_fail_stage",  32'(err_stage), 32'd1);
      ack_dly = 3;
      do_reset();

      // reset in the middle of WAIT with occ = 0110
      exp_q.push_back(4'b0001);
      exp_q.push_back(4'b0011);
      exp_q.push_back(4'b0110);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      wait_idle(40, n);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      wait_idle(40, n);
      chk("mw_occ_0011", 32'(occ), 32'h3);
      step();
      repeat (3) step();
      chk("mw_occ_pre", 32'(occ), 32'h6);
      rst = 1'b1;
      #1;
      chk("mw_rst_occ",      32'(occ),      32'd0);
      chk("mw_rst_stage_ld", 32'(stage_ld), 32'd0);
      chk("mw_rst_in_ready", 32'(in_ready), 32'd0);
      step();
      rst = 1'b0;
      #1;
      chk("mw_rel_in_ready", 32'(in_ready), 32'd1);
      exp_q.push_back(4'b0001);
      exp_q.push_back(4'b0010);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      wait_idle(40, n);
      chk("mw_new_period", 32'(n),   32'd6);
      chk("mw_new_occ0",   32'(occ), 32'h1);
      step();
      wait_idle(40, n);
      chk("mw_new_occ1",   32'(occ), 32'h2);
      chk("mw_q_empty",    32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
